// File: rtl/toaplan2_snd_mixer_if.sv
// toaplan2_snd_mixer_if: channel samples, gains and mute in; mixed sample and status out.
interface toaplan2_snd_mixer_if #(parameter int CH = 4, parameter int W = 16, parameter int WOUT = 16);
   logic                   CEN;
   logic [CH*W-1:0]        CH_DATA;
   logic [CH*8-1:0]        CH_GAIN;
   logic [CH-1:0]          CH_MUTE;
   logic signed [WOUT-1:0] MIXED;
   logic                   SAMPLE;
   logic                   PEAK;
   logic                   BUSY;
   logic                   OVERRUN;
   modport master (output CEN, CH_DATA, CH_GAIN, CH_MUTE, input MIXED, SAMPLE, PEAK, BUSY, OVERRUN);
   modport slave (input CEN, CH_DATA, CH_GAIN, CH_MUTE, output MIXED, SAMPLE, PEAK, BUSY, OVERRUN);
endinterface

// File: rtl/toaplan2_snd_mixer.sv
// toaplan2_snd_mixer: one-MAC-per-clock N-channel mixer with slew-limited 4.4 gains
// and a saturating registered output.
module toaplan2_snd_mixer #(
   parameter int CH = 4,
   parameter int W = 16,
   parameter int WOUT = 16,
   parameter int RAMP_STEP = 0
) (
   input logic CLK,
   input logic RESET,
   toaplan2_snd_mixer_if.slave bus
);
   localparam int CW = $clog2(CH);
   localparam int AW = W + 8 + CW;
   localparam logic [7:0] STEP = RAMP_STEP > 255 ? 8'd255 : 8'(RAMP_STEP);
   localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (WOUT - 1)) - 64'sd1);
   localparam logic signed [AW-1:0] MINV = ~MAXV;
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
   state_t state, nxt_state;
   logic [CW-1:0] cnt;
   logic signed [AW-1:0] acc, sh;
   logic signed [W+8:0] prod;
   logic signed [W-1:0] snap [CH];
   logic [7:0] cur_gain [CH], tgt [CH], diff [CH], nxt_gain [CH];
   logic signed [WOUT-1:0] mixed;
   logic sample, peak, overrun, accept, sat;
   assign accept = state == IDLE && bus.CEN && !sample;
   always_comb
      for (int i = 0; i < CH; i++) begin
         tgt[i] = bus.CH_MUTE[i] ? 8'd0 : bus.CH_GAIN[i*8 +: 8];
         diff[i] = tgt[i] > cur_gain[i] ? tgt[i] - cur_gain[i] : cur_gain[i] - tgt[i];
         nxt_gain[i] = (RAMP_STEP == 0 || diff[i] <= STEP) ? tgt[i] :
                       tgt[i] > cur_gain[i] ? cur_gain[i] + STEP : cur_gain[i] - STEP;
      end
   // signed sample times unsigned gain, widened so the product never wraps
   assign prod = (W+9)'(snap[cnt]) * (W+9)'($signed({1'b0, cur_gain[cnt]}));
   assign sh = acc >>> 4;
   assign sat = sh > MAXV || sh < MINV;
   always_ff @(posedge CLK)
      state <= RESET ? IDLE : nxt_state;
   always_comb
      nxt_state = state == IDLE ? (accept ? ACC : IDLE) :
                  state == ACC ? (cnt == CW'(CH - 1) ? OUT : ACC) : IDLE;
   always_comb
      bus.BUSY = state != IDLE;
   always_ff @(posedge CLK)
      if (RESET) begin
         acc <= '0;
         cnt <= '0;
         mixed <= '0;
         sample <= 1'b0;
         peak <= 1'b0;
         overrun <= 1'b0;
         for (int i = 0; i < CH; i++) cur_gain[i] <= 8'd0;
      end else begin
         sample <= state == OUT;
         if (bus.CEN && !accept) overrun <= 1'b1;
         if (accept) begin
            for (int i = 0; i < CH; i++) begin
               snap[i] <= bus.CH_DATA[i*W +: W];
               cur_gain[i] <= nxt_gain[i];
            end
            acc <= '0;
            cnt <= '0;
         end
         if (state == ACC) begin
            acc <= acc + AW'(prod);
            cnt <= cnt + 1'b1;
         end
         if (state == OUT) begin
            mixed <= WOUT'(sh > MAXV ? MAXV : sh < MINV ? MINV : sh);
            peak <= sat;
         end
      end
   assign bus.MIXED = mixed;
   assign bus.SAMPLE = sample;
   assign bus.PEAK = peak;
   assign bus.OVERRUN = overrun;
endmodule

// File: tb/tb_toaplan2_snd_mixer.sv
// tb_toaplan2_snd_mixer: two mixers (immediate gains and RAMP_STEP=4) driven alike and
// compared every cycle against a sample-level model, plus literal directed cases.
module tb_toaplan2_snd_mixer;
   localparam int CH = 4;
   logic CLK = 0, rst = 1, cen = 0;
   logic [CH*16-1:0] ch_data = '0;
   logic [CH*8-1:0] ch_gain = '0;
   logic [CH-1:0] ch_mute = '0;
   int checks = 0, errs = 0, cyc = 0, nsamp = 0;
   bit armed = 0;
   toaplan2_snd_mixer_if #(.CH(CH), .W(16), .WOUT(16)) ifa ();
   toaplan2_snd_mixer_if #(.CH(CH), .W(16), .WOUT(16)) ifb ();
   assign ifa.CEN = cen;
   assign ifa.CH_DATA = ch_data;
   assign ifa.CH_GAIN = ch_gain;
   assign ifa.CH_MUTE = ch_mute;
   assign ifb.CEN = cen;
   assign ifb.CH_DATA = ch_data;
   assign ifb.CH_GAIN = ch_gain;
   assign ifb.CH_MUTE = ch_mute;
   toaplan2_snd_mixer #(.CH(CH), .W(16), .WOUT(16), .RAMP_STEP(0)) dut0 (.CLK(CLK), .RESET(rst), .bus(ifa.slave));
   toaplan2_snd_mixer #(.CH(CH), .W(16), .WOUT(16), .RAMP_STEP(4)) dut4 (.CLK(CLK), .RESET(rst), .bus(ifb.slave));
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic int step(input int cur, input int tgt, input int rs);
      int d;
      d = tgt - cur;
      if (rs == 0 || (d <= rs && d >= -rs)) return tgt;
      return d > 0 ? cur + rs : cur - rs;
   endfunction

   // reference model: one entry per accepted request, due when its sample must appear
   typedef struct {int due; int v0; int v1; bit p0; bit p1;} exp_t;
   exp_t q[$];
   int g [2][CH];
   int m_mixed [2];
   bit m_peak [2];
   bit m_sample = 0, m_ovr = 0;
   int free_at = 0, busy_until = -1;

   initial forever begin
      exp_t e;
      int s, tg;
      int tv [2];
      bit tp [2];
      @(posedge CLK);
      cyc++;
      m_sample = 0;
      if (rst) begin
         q.delete();
         for (int d = 0; d < 2; d++) begin
            m_mixed[d] = 0;
            m_peak[d] = 0;
            for (int i = 0; i < CH; i++) g[d][i] = 0;
         end
         m_ovr = 0;
         free_at = 0;
         busy_until = -1;
         armed = 1;
      end else begin
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            m_mixed[0] = e.v0;
            m_mixed[1] = e.v1;
            m_peak[0] = e.p0;
            m_peak[1] = e.p1;
            m_sample = 1;
         end
         if (cen) begin
            if (cyc >= free_at) begin
               for (int d = 0; d < 2; d++) begin
                  s = 0;
                  for (int i = 0; i < CH; i++) begin
                     tg = ch_mute[i] ? 0 : int'(ch_gain[i*8 +: 8]);
                     g[d][i] = step(g[d][i], tg, d == 1 ? 4 : 0);
                     s += int'($signed(ch_data[i*16 +: 16])) * g[d][i];
                  end
                  s = s >>> 4;
                  tp[d] = s > 32767 || s < -32768;
                  tv[d] = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
               end
               e.due = cyc + CH + 1;
               e.v0 = tv[0];
               e.v1 = tv[1];
               e.p0 = tp[0];
               e.p1 = tp[1];
               q.push_back(e);
               free_at = cyc + CH + 3;
               busy_until = cyc + CH;
            end else m_ovr = 1;
         end
      end
   end

   initial forever begin
      @(negedge CLK);
      if (armed) begin
         if (ifa.SAMPLE === 1'b1) nsamp++;
         chk("sample_r0", ifa.SAMPLE, m_sample);
         chk("sample_r4", ifb.SAMPLE, m_sample);
         chk("mixed_r0", $signed(ifa.MIXED), m_mixed[0]);
         chk("mixed_r4", $signed(ifb.MIXED), m_mixed[1]);
         chk("peak_r0", ifa.PEAK, m_peak[0]);
         chk("peak_r4", ifb.PEAK, m_peak[1]);
         chk("busy_r0", ifa.BUSY, cyc <= busy_until);
         chk("busy_r4", ifb.BUSY, cyc <= busy_until);
         chk("overrun_r0", ifa.OVERRUN, m_ovr);
         chk("overrun_r4", ifb.OVERRUN, m_ovr);
      end
   end

   task automatic do_mix(input int d0, input int d1, input logic [7:0] gn, input logic [3:0] mu,
                         output int r0, output int r4, output int pk, output int lat);
      int c0;
      bit seen;
      @(negedge CLK);
      ch_data = {16'd0, 16'd0, 16'(d1), 16'(d0)};
      ch_gain = {4{gn}};
      ch_mute = mu;
      cen = 1;
      c0 = cyc;
      @(negedge CLK);
      cen = 0;
      seen = 0;
      for (int w = 0; w < 20 && !seen; w++) begin
         @(negedge CLK);
         if (ifa.SAMPLE === 1'b1) seen = 1;
      end
      chk("sample_seen", seen, 1);
      r0 = $signed(ifa.MIXED);
      r4 = $signed(ifb.MIXED);
      pk = ifa.PEAK;
      lat = cyc - c0;
   endtask

   task automatic pulse_rst();
      @(negedge CLK);
      rst = 1;
      @(negedge CLK);
      rst = 0;
   endtask

   initial begin
      int r0, r4, pk, lat, n0;
      int ramp [10];
      ramp = '{400, 800, 1200, 1600, 1600, 1200, 800, 400, 0, 0};
      repeat (2) @(negedge CLK);
      rst = 0;
      @(negedge CLK);
      chk("reset_mixed", $signed(ifa.MIXED), 0);
      chk("reset_busy", ifa.BUSY, 0);
      do_mix(1000, 0, 8'h10, 4'h0, r0, r4, pk, lat);
      chk("unity_pos", r0, 1000);
      chk("unity_peak", pk, 0);
      chk("latency", lat, 6);
      do_mix(-1000, 0, 8'h10, 4'h0, r0, r4, pk, lat);
      chk("unity_neg", r0, -1000);
      do_mix(20000, 20000, 8'h10, 4'h0, r0, r4, pk, lat);
      chk("sat_hi", r0, 32767);
      chk("sat_hi_peak", pk, 1);
      do_mix(-20000, -20000, 8'h10, 4'h0, r0, r4, pk, lat);
      chk("sat_lo", r0, -32768);
      chk("sat_lo_peak", pk, 1);
      do_mix(5, 0, 8'h10, 4'h0, r0, r4, pk, lat);
      chk("after_sat", r0, 5);
      chk("after_sat_peak", pk, 0);
      do_mix(-1000, 0, 8'h08, 4'h0, r0, r4, pk, lat);
      chk("half_gain", r0, -500);
      do_mix(1000, 0, 8'h18, 4'h0, r0, r4, pk, lat);
      chk("gain_1p5", r0, 1500);
      do_mix(-1, 0, 8'h08, 4'h0, r0, r4, pk, lat);
      chk("floor", r0, -1);
      chk("no_overrun_yet", ifa.OVERRUN, 0);
      // second request two cycles into the first mix is dropped
      n0 = nsamp;
      @(negedge CLK);
      ch_data = {48'd0, 16'd1234};
      ch_gain = {4{8'h10}};
      cen = 1;
      @(negedge CLK);
      cen = 0;
      @(negedge CLK);
      ch_data = {48'd0, 16'd777};
      cen = 1;
      @(negedge CLK);
      cen = 0;
      repeat (10) @(negedge CLK);
      chk("overrun_one_sample", nsamp - n0, 1);
      chk("overrun_flag", ifa.OVERRUN, 1);
      chk("overrun_mixed", $signed(ifa.MIXED), 1234);
      pulse_rst();
      for (int k = 0; k < 10; k++) begin
         do_mix(1600, 0, 8'h10, k < 5 ? 4'h0 : 4'h1, r0, r4, pk, lat);
         chk("ramp", r4, ramp[k]);
      end
      // reset lands while a mix is in flight
      n0 = nsamp;
      @(negedge CLK);
      ch_mute = 4'h0;
      cen = 1;
      @(negedge CLK);
      cen = 0;
      @(negedge CLK);
      rst = 1;
      @(negedge CLK);
      rst = 0;
      repeat (8) @(negedge CLK);
      chk("rst_nosample", nsamp - n0, 0);
      chk("rst_mixed", $signed(ifb.MIXED), 0);
      chk("rst_busy", ifb.BUSY, 0);
      chk("rst_overrun", ifb.OVERRUN, 0);
      do_mix(1600, 0, 8'h10, 4'h0, r0, r4, pk, lat);
      chk("rst_reramp", r4, 400);
      chk("rst_immediate", r0, 1600);
      for (int n = 0; n < 3000; n++) begin
         @(negedge CLK);
         rst = $urandom_range(0, 599) == 0;
         cen = $urandom_range(0, 2) == 0;
         for (int i = 0; i < CH; i++) begin
            ch_data[i*16 +: 16] = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 40) - 20) : 16'($urandom);
            ch_gain[i*8 +: 8] = $urandom_range(0, 1) == 1 ? 8'h10 : 8'($urandom);
         end
         ch_mute = 4'($urandom) & 4'($urandom) & 4'($urandom);
      end
      @(negedge CLK);
      rst = 0;
      cen = 0;
      repeat (20) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/toaplan2_snd_mixer.md
Name: toaplan2_snd_mixer

Overview:
- Parametrised, time-multiplexed N-channel audio mixer for the toaplan2 sound path. Successor to the fixed 4-input mixer stage.
- One multiply-accumulate per clock, sequenced across channels.
- Per-channel gains are 4.4 fixed point and slew-limited (click-free changes of FX level and mute).
- Output is saturating, with a peak flag, a sample strobe and an overrun flag.
- Sits between the FM/ADPCM cores and the top-level audio output. Runs on the sound clock.

Parameters:
- CH, 4: number of input channels (2..16).
- W, 16: input sample width, signed. Narrower sources are sign-extended by the instantiator.
- WOUT, 16: output sample width, signed.
- RAMP_STEP, 0: maximum gain change per output sample, in gain LSBs. 0 means the target gain is applied immediately.

Ports:
- CLK  in  1  sound clock. Single clock domain.
- RESET  in  1  synchronous, active-high reset.
- CEN  in  1  sample request pulse, one CLK wide.
- CH_DATA  in  CH*W  channel samples, signed. Channel i occupies bits [i*W +: W].
- CH_GAIN  in  CH*8  target gains, 4.4 unsigned (0x10 = unity). Channel i occupies bits [i*8 +: 8].
- CH_MUTE  in  CH  per-channel mute. Forces that channel's target gain to 0.
- MIXED  out  WOUT  mixed output, signed, registered.
- SAMPLE  out  1  one-cycle pulse; MIXED updates in the same cycle.
- PEAK  out  1  high when the current MIXED value was saturated.
- BUSY  out  1  high while a mix is in progress.
- OVERRUN  out  1  sticky; set when CEN arrives while BUSY.

Behaviour:
- Reset (synchronous; overrides any state, including mid-mix):
  - MIXED=0, SAMPLE=0, PEAK=0, BUSY=0, OVERRUN=0.
  - Accumulator=0, channel counter=0, state=IDLE.
  - All current gains cur_gain[i]=0.
- State IDLE:
  - On CEN=1: snapshot CH_DATA, and snapshot tgt[i] = CH_MUTE[i] ? 0 : CH_GAIN[i].
  - Step every cur_gain toward its tgt:
    - RAMP_STEP=0, or |tgt-cur| <= RAMP_STEP: cur = tgt.
    - Otherwise cur = cur ± RAMP_STEP.
  - Clear the accumulator, set counter=0, go to ACC. BUSY=1 from the next cycle.
- State ACC:
  - Each cycle: acc += snap[cnt] * cur_gain[cnt], signed × unsigned.
  - The stepped gain is the one used in this sample.
  - Accumulator width is W+8+clog2(CH); no internal overflow is possible.
  - After channel CH-1, go to OUT.
- State OUT:
  - res = acc >>> 4 (arithmetic shift, floor rounding).
  - Saturate to [-2^(WOUT-1), 2^(WOUT-1)-1].
  - Register MIXED=res. PEAK=1 if saturation occurred, else 0. PEAK holds until the next SAMPLE.
  - Pulse SAMPLE=1 for one cycle, BUSY=0, return to IDLE.
- Latency: CEN at cycle t gives SAMPLE and the new MIXED at cycle t+CH+2. MIXED holds its value between SAMPLE pulses.
- CEN while BUSY or in OUT:
  - The request is dropped and OVERRUN is set (sticky until RESET).
  - The in-flight mix completes unaffected.
- CEN in the same cycle SAMPLE is asserted counts as busy and is dropped.
- CH_DATA, CH_GAIN and CH_MUTE changes during a mix have no effect until the next accepted CEN.
- Gain 0 with any data contributes exactly 0. Unity gain is bit-exact passthrough (before saturation).

Test Plan:
- Unity passthrough (CH=4, W=16, RAMP_STEP=0, all gains 0x10):
  - ch0=1000, others 0, CEN at t → SAMPLE at t+6, MIXED=1000, PEAK=0.
  - Same settings: ch0=-1000 gives -1000.
- Saturation:
  - ch0=ch1=20000 → MIXED=32767, PEAK=1.
  - ch0=ch1=-20000 → MIXED=-32768, PEAK=1.
  - Next sample with ch0=5, others 0 → MIXED=5, PEAK=0.
- Fractional gains:
  - gain 0x08, ch0=-1000 → -500.
  - gain 0x18, ch0=1000 → 1500.
  - gain 0x08, ch0=-1 → -1 (floor).
- Ramp (RAMP_STEP=4, ch0=1600, target 0x10 from reset):
  - Five CENs → MIXED 400, 800, 1200, 1600, 1600.
  - Then set CH_MUTE[0]=1 → next outputs 1200, 800, 400, 0, 0.
- Overrun: CEN at t and again at t+2 → exactly one SAMPLE (t+6), OVERRUN=1 from t+3, MIXED equals the first mix.
- Reset mid-mix: RESET at t+3 after CEN → no SAMPLE, MIXED=0, BUSY=0, OVERRUN=0. A following CEN with RAMP_STEP=4 ramps again from gain 0.
